// File: rtl/axi_rd_fifo_fsm_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and axi_rd_fifo_fsm.
//   master: drives AR channel and rready, receives R channel
//   slave : receives AR channel and rready, drives arready and R channel
interface axi_rd_fifo_fsm_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_fifo_fsm.sv
// AXI4 read-channel sequencer serving NUM_FIFO show-ahead output FIFOs.
// Read commands are queued (up to CMD_DEPTH); the queue head is served one
// beat per R handshake, popping the FIFO selected by araddr[SEL_LSB +: SEL_W].
// Out-of-range selects and FIFO-stall timeouts produce SLVERR beats.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   axs_s0            AXI read slave (AR in, R out)
//   out_fifo_empty    per-FIFO empty flags
//   out_fifo_pop      pop strobe for the selected FIFO
//   out_fifo_pop_sel  index of the selected FIFO (also drives the external data mux)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | head burst served normally (pop beats, or error beats if bad select)
// ST_ABORT | head burst timed out; remaining beats are SLVERR without pops
module axi_rd_fifo_fsm #(
  parameter int NUM_FIFO  = 4,
  parameter int SEL_W     = 2,
  parameter int ID_W      = 4,
  parameter int SEL_LSB   = 12,
  parameter int CMD_DEPTH = 2,
  parameter int TIMEOUT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  axi_rd_fifo_fsm_if.slave    axs_s0,
  input  logic [NUM_FIFO-1:0] out_fifo_empty,
  output logic                out_fifo_pop,
  output logic [SEL_W-1:0]    out_fifo_pop_sel
);
  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int SLOTS = 1 << PTR_W;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_RUN, ST_ABORT} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  q_id_q  [SLOTS];
  logic [ID_W-1:0]  q_id_d  [SLOTS];
  logic [7:0]       q_len_q [SLOTS];
  logic [7:0]       q_len_d [SLOTS];
  logic [SEL_W-1:0] q_sel_q [SLOTS];
  logic [SEL_W-1:0] q_sel_d [SLOTS];
  logic             q_err_q [SLOTS];
  logic             q_err_d [SLOTS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       beat_q, beat_d;
  logic [15:0]      stall_q, stall_d;

  logic [SEL_W-1:0]      ar_sel;
  logic                  ar_err;
  logic                  arready;
  logic                  push;
  logic                  pop_head;
  logic                  head_valid;
  logic                  pop_beat;
  logic                  rvalid;
  logic                  rlast;
  logic                  handshake;
  logic                  stalled;
  logic [(1<<SEL_W)-1:0] empty_pad;
  logic                  unused_bits;

  // Size and burst type are irrelevant: every beat is one FIFO entry.
  assign unused_bits = ^{axs_s0.arsize, axs_s0.arburst, axs_s0.araddr};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ar_sel = axs_s0.araddr[SEL_LSB +: SEL_W];
  assign ar_err = (int'(ar_sel) >= NUM_FIFO);

  // Registered count only, so a pop in this cycle never frees a slot for a
  // push in the same cycle and arvalid has no path to arready.
  assign arready = !reset && (cnt_q < CNT_W'(CMD_DEPTH));
  assign push    = axs_s0.arvalid && arready;

  // Unimplemented select codes read as empty; they are always error beats anyway.
  always_comb begin
    empty_pad = '1;
    for (int i = 0; i < NUM_FIFO; i++) empty_pad[i] = out_fifo_empty[i];
  end

  // Outputs are gated by reset so nothing is presented while reset is held.
  assign head_valid = !reset && (cnt_q != '0);
  assign pop_beat   = !q_err_q[rd_ptr_q] && (state_q == ST_RUN);
  assign rvalid     = head_valid && (pop_beat ? !empty_pad[q_sel_q[rd_ptr_q]] : 1'b1);
  assign rlast      = head_valid && (beat_q == q_len_q[rd_ptr_q]);
  assign handshake  = rvalid && axs_s0.rready;
  assign pop_head   = handshake && rlast;
  assign stalled    = head_valid && pop_beat && !rvalid;

  always_comb begin
    axs_s0.arready   = arready;
    axs_s0.rvalid    = rvalid;
    axs_s0.rlast     = rlast;
    axs_s0.rid       = '0;
    axs_s0.rresp     = RESP_OKAY;
    out_fifo_pop     = 1'b0;
    out_fifo_pop_sel = '0;
    if (head_valid) begin
      axs_s0.rid       = q_id_q[rd_ptr_q];
      out_fifo_pop_sel = q_sel_q[rd_ptr_q];
      axs_s0.rresp     = pop_beat ? RESP_OKAY : RESP_SLVERR;
      out_fifo_pop     = pop_beat && handshake;
    end
  end

  always_comb begin
    q_id_d   = q_id_q;
    q_len_d  = q_len_q;
    q_sel_d  = q_sel_q;
    q_err_d  = q_err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      q_id_d[wr_ptr_q]  = axs_s0.arid;
      q_len_d[wr_ptr_q] = axs_s0.arlen;
      q_sel_d[wr_ptr_q] = ar_sel;
      q_err_d[wr_ptr_q] = ar_err;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop_head) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop_head)      cnt_d = cnt_q + 1'b1;
    else if (pop_head && !push) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    if (handshake) begin
      stall_d = '0;
      if (rlast) begin
        beat_d  = '0;
        state_d = ST_RUN;
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end else if (stalled) begin
      // TIMEOUT-1 here means the abort lands after TIMEOUT stalled cycles.
      if ((TIMEOUT != 0) && (stall_q == 16'(TIMEOUT - 1))) begin
        state_d = ST_ABORT;
        stall_d = '0;
      end else if (stall_q != 16'hffff) begin
        stall_d = stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      stall_q  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        q_id_q[i]  <= '0;
        q_len_q[i] <= '0;
        q_sel_q[i] <= '0;
        q_err_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
      q_id_q   <= q_id_d;
      q_len_q  <= q_len_d;
      q_sel_q  <= q_sel_d;
      q_err_q  <= q_err_d;
    end
  end
endmodule

// File: tb/tb_axi_rd_fifo_fsm.sv
// Bench for axi_rd_fifo_fsm: directed scenarios plus a randomized phase.
// Accepted ARs go into a command scoreboard; a negedge monitor derives every
// expected R beat from the command list, its own FIFO fill levels and a
// stall-cycle count, and compares against the DUT.
module tb_axi_rd_fifo_fsm;
  localparam int NF      = 3;
  localparam int SW      = 2;
  localparam int IW      = 4;
  localparam int DEPTH   = 2;
  localparam int TMO     = 8;

  typedef struct {
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [SW-1:0] sel;
    bit            err;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] fifo_empty;
  logic          fifo_pop;
  logic [SW-1:0] fifo_pop_sel;

  axi_rd_fifo_fsm_if #(.ID_W(IW)) bus ();

  axi_rd_fifo_fsm #(
    .NUM_FIFO(NF), .SEL_W(SW), .ID_W(IW), .SEL_LSB(12),
    .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .axs_s0(bus),
    .out_fifo_empty(fifo_empty),
    .out_fifo_pop(fifo_pop),
    .out_fifo_pop_sel(fifo_pop_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- FIFO fill-level model ----------------
  int         level [NF];
  bit         pend_pop = 0;
  logic [1:0] pend_sel = '0;
  bit         rf_en = 0, df_en = 0;
  int         rf_idx = 0, df_idx = 0, rf_amt = 0, df_amt = 0;

  initial for (int i = 0; i < NF; i++) level[i] = 0;

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (reset) level[i] <= 0;
      else level[i] <= level[i]
                       - ((pend_pop && int'(pend_sel) == i) ? 1 : 0)
                       + ((rf_en && rf_idx == i) ? rf_amt : 0)
                       + ((df_en && df_idx == i) ? df_amt : 0);
    end
  end

  always_comb begin
    for (int i = 0; i < NF; i++) fifo_empty[i] = (level[i] == 0);
  end

  // ---------------- reference model + monitor ----------------
  cmd_t cq[$];
  cmd_t m_head;
  int   m_beat = 0, m_stall = 0;
  bit   m_abort = 0, m_rdy, m_popb, m_ev;
  int   n_slverr = 0, n_pops = 0;

  always @(negedge clk) begin
    pend_pop = 0;
    if (reset) begin
      chk("reset_outputs",
          {bus.arready, bus.rvalid, bus.rlast, bus.rresp, bus.rid, fifo_pop, fifo_pop_sel},
          '0);
      cq.delete();
      m_beat = 0; m_stall = 0; m_abort = 0;
    end else begin
      m_rdy = (cq.size() < DEPTH);
      chk("arready", bus.arready, m_rdy);
      if (cq.size() > 0) begin
        m_head = cq[0];
        m_popb = !m_head.err && !m_abort;
        m_ev   = m_popb ? (level[m_head.sel] > 0) : 1'b1;
        chk("rvalid", bus.rvalid, m_ev);
        if (m_ev) begin
          chk("rid", bus.rid, m_head.id);
          chk("rlast", bus.rlast, (m_beat == int'(m_head.len)));
          chk("rresp", bus.rresp, m_popb ? 2'b00 : 2'b10);
          chk("pop", fifo_pop, m_popb && bus.rready);
          if (m_popb) chk("pop_sel", fifo_pop_sel, m_head.sel);
        end else begin
          chk("pop_stalled", fifo_pop, 1'b0);
        end
        if (m_ev && bus.rready) begin
          if (m_popb) begin pend_pop = 1; pend_sel = m_head.sel; n_pops++; end
          else n_slverr++;
          m_stall = 0;
          if (m_beat == int'(m_head.len)) begin
            void'(cq.pop_front());
            m_beat = 0; m_abort = 0;
          end else begin
            m_beat++;
          end
        end else if (m_popb && !m_ev) begin
          m_stall++;
          if (m_stall == TMO) begin m_abort = 1; m_stall = 0; end
        end
      end else begin
        chk("rvalid_idle", bus.rvalid, 1'b0);
        chk("pop_idle", fifo_pop, 1'b0);
      end
      if (bus.arvalid && m_rdy) begin
        m_head.id  = bus.arid;
        m_head.len = bus.arlen;
        m_head.sel = bus.araddr[13:12];
        m_head.err = (int'(bus.araddr[13:12]) >= NF);
        cq.push_back(m_head);
      end
    end
  end

  // ---------------- background drivers ----------------
  int rr_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random
  bit refill_on = 0;

  initial begin
    bus.rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.rready = 1'b0;
        1:       bus.rready = 1'b1;
        2:       bus.rready = !bus.rready;
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rf_en = 0;
      if (refill_on && $urandom_range(0, 2) == 0) begin
        rf_en  = 1;
        rf_idx = $urandom_range(0, NF - 1);
        rf_amt = $urandom_range(1, 3);
      end
    end
  end

  // ---------------- stimulus tasks (all start/end at posedge+1) ----------------
  task automatic fill(input int idx, input int amt);
    df_en = 1; df_idx = idx; df_amt = amt;
    @(posedge clk); #1;
    df_en = 0;
  endtask

  task automatic send_ar(input int id, input int sel, input int len);
    logic [31:0] a;
    bit acc;
    int t;
    a = $urandom;
    a[13:12] = sel[1:0];
    bus.arid    = id[IW-1:0];
    bus.araddr  = a;
    bus.arlen   = len[7:0];
    bus.arsize  = 3'($urandom_range(0, 7));
    bus.arburst = 2'($urandom_range(0, 3));
    bus.arvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk); acc = bus.arready;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 2000) begin
        n_checks++; n_err++;
        $display("FAIL ar_accept_timeout: arready never seen, required within 2000 cycles");
        break;
      end
    end
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    forever begin
      @(negedge clk); #1;
      if (cq.size() == 0) break;
      t++;
      if (t > budget) begin
        n_checks++; n_err++;
        $display("FAIL idle_timeout: %0d commands pending, required 0 within %0d cycles", cq.size(), budget);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int pops_before, slv_before;

  initial begin
    reset = 1'b1;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0;
    idle_cycles(3);
    reset = 1'b0;

    // single burst, rready held high
    fill(2, 4); rr_mode = 1;
    pops_before = n_pops;
    send_ar(1, 2, 3); wait_idle(50);
    chk("single_pop_count", n_pops - pops_before, 4);

    // back-pressure with toggling rready
    fill(2, 4); rr_mode = 2;
    pops_before = n_pops;
    send_ar(2, 2, 3); wait_idle(50);
    chk("bp_pop_count", n_pops - pops_before, 4);

    // queue full: three back-to-back ARs while rready is low
    rr_mode = 0; fill(0, 8);
    fork
      begin send_ar(3, 0, 1); send_ar(4, 0, 1); send_ar(5, 0, 1); end
      begin idle_cycles(6); rr_mode = 1; end
    join
    wait_idle(50);

    // out-of-range select
    slv_before = n_slverr; pops_before = n_pops;
    send_ar(6, 3, 1); wait_idle(50);
    chk("badsel_slverr_beats", n_slverr - slv_before, 2);
    chk("badsel_no_pops", n_pops - pops_before, 0);

    // stall timeout: one entry available for a 4-beat burst
    fill(1, 1);
    slv_before = n_slverr; pops_before = n_pops;
    send_ar(7, 1, 3); wait_idle(100);
    chk("tmo_pops", n_pops - pops_before, 1);
    chk("tmo_slverr_beats", n_slverr - slv_before, 3);
    fill(1, 4);
    slv_before = n_slverr;
    send_ar(8, 1, 3); wait_idle(50);
    chk("after_tmo_no_slverr", n_slverr - slv_before, 0);

    // 256-beat burst
    fill(0, 300);
    pops_before = n_pops;
    send_ar(9, 0, 255); wait_idle(400);
    chk("len255_pops", n_pops - pops_before, 256);

    // reset in the middle of a burst
    fill(2, 8);
    send_ar(10, 2, 7);
    idle_cycles(4);
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    fill(2, 4);
    pops_before = n_pops;
    send_ar(11, 2, 2); wait_idle(50);
    chk("post_reset_pops", n_pops - pops_before, 3);

    // randomized traffic
    refill_on = 1; rr_mode = 3;
    for (int k = 0; k < 300; k++) begin
      send_ar($urandom_range(0, 15), $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7));
      idle_cycles($urandom_range(0, 2));
    end
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
